// File: rtl/save_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : save_serializer
//  Purpose  : Snapshots the 2-bit-per-cell encoded board on a save request and
//             streams it out one cell per valid/ready transfer, in cell-index
//             order, flagging any symbol that is not one-hot (00 or 11).
//  Ports    : clk        - clock, rising edge
//             resetn     - synchronous active-low reset
//             save_req   - start request, honoured only when idle
//             save_vals  - encoded board, cell i at bits [2i+1:2i]
//             out_valid  - symbol on out_data/out_addr is valid
//             out_ready  - downstream accepts the symbol this cycle
//             out_data   - encoded symbol of current cell
//             out_addr   - index of current cell
//             out_last   - current symbol is cell N-1
//             busy       - a save is in progress (not idle)
//             done       - one-cycle pulse after the final transfer
//             enc_error  - sticky: an invalid symbol was transferred
//  Revision : 1.0 - initial release
// ============================================================================
module save_serializer #(
  parameter  int BOARD_LENGTH = 5,
  parameter  int BOARD_HEIGHT = 5,
  localparam int N            = BOARD_LENGTH * BOARD_HEIGHT,
  localparam int ADDR_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              save_req,
  input  logic [2*N-1:0]    save_vals,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              enc_error
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [2*N-1:0]    shadow_q, shadow_d;
  logic              err_q, err_d;

  logic [1:0]        cur_sym;
  logic              is_last;
  logic              xfer;

  // Select the symbol of the current cell out of the snapshot.
  always_comb begin
    cur_sym = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (idx_q == ADDR_W'(i)) begin
        cur_sym = shadow_q[2*i +: 2];
      end
    end
  end

  assign is_last = (idx_q == LAST_IDX);
  assign xfer    = (state_q == SEND) && out_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (save_req) begin
          shadow_d = save_vals;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          // Valid symbols are one-hot; equal bits mean corruption.
          if (cur_sym[1] == cur_sym[0]) begin
            err_d = 1'b1;
          end
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  // Outputs are decoded from registered state only; data and address are
  // forced to zero outside SEND so idle outputs are clean.
  always_comb begin
    out_valid = (state_q == SEND);
    out_data  = (state_q == SEND) ? cur_sym : 2'b00;
    out_addr  = (state_q == SEND) ? idx_q : '0;
    out_last  = (state_q == SEND) && is_last;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    enc_error = err_q;
  end

endmodule
`default_nettype wire
